noc_credit_rx_port: RTL

//  Receiving end of the PE->router credit link: accepts 20-bit flits (datain/in_valid) into a FIFO.

---
 rtl/noc_credit_rx_port.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/noc_credit_rx_port.sv
// Credit-link receive port: buffers incoming flits in a FIFO, returns one credit (co) per drained or dropped flit.
// Latency: 1 cycle from push to first-word-fall-through output; co is registered 1 cycle after each pop or drop.
// Backpressure: out_ready stalls the head; a flit arriving at a full FIFO with no pop is dropped and sets sticky overflow.
// Optional flit-sequence checker is built when the PKT_CHECK_EN macro is defined.
module noc_credit_rx_port #(
    parameter int DW    = 20,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] datain,
    input  logic          in_valid,
    output logic          co,
    output logic [DW-1:0] dataout,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW:0]   occupancy,
    output logic          overflow,
    output logic          pkt_err,
    output logic [7:0]    err_cnt
);

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [DW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   occ_q, occ_d;
    logic          co_q, co_d;
    logic          pend_q, pend_d;
    logic          ovf_q, ovf_d;

    logic          push;
    logic          pop;
    logic          drop;
    logic [1:0]    cred_n;

    // Handshake decode: a pop frees a slot in the same cycle, so a full FIFO can still accept.
    always_comb begin
        out_valid = (occ_q != '0);
        pop       = out_valid & out_ready;
        push      = in_valid & ((occ_q < DEPTH_C) | pop);
        drop      = in_valid & ~push;
        dataout   = out_valid ? mem[rd_ptr_q] : '0;
    end

    // Next-state for pointers, occupancy, credit return and overflow.
    // Pop and drop are mutually exclusive, but a deferred credit can coincide with either;
    // co carries one credit per cycle and any second credit waits in pend.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + (AW+1)'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - (AW+1)'(1);
        end
        cred_n = {1'b0, pop} + {1'b0, drop} + {1'b0, pend_q};
        co_d   = (cred_n != 2'd0);
        pend_d = cred_n[1];
        ovf_d  = ovf_q | drop;
    end

    // Control state registers; stored flits are discarded by resetting the pointers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            co_q     <= 1'b0;
            pend_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            co_q     <= co_d;
            pend_q   <= pend_d;
            ovf_q    <= ovf_d;
        end
    end

    // Flit storage; contents need no reset because dataout is gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= datain;
        end
    end

    assign co        = co_q;
    assign occupancy = occ_q;
    assign overflow  = ovf_q;

`ifdef PKT_CHECK_EN
    localparam logic [1:0] TY_BODY = 2'b00;
    localparam logic [1:0] TY_HEAD = 2'b01;
    localparam logic [1:0] TY_TAIL = 2'b10;
    localparam logic [1:0] TY_HT   = 2'b11;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BODY = 1'b1
    } chk_state_e;

    chk_state_e state_q, state_d;
    logic       chk_err;
    logic       pkt_err_q, pkt_err_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [1:0] flit_ty;

    assign flit_ty = datain[DW-1:DW-2];

    // Checker state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Checker next state: every presented flit is tracked, dropped ones included.
    always_comb begin
        state_d = state_q;
        if (in_valid) begin
            case (state_q)
                S_IDLE: if (flit_ty == TY_HEAD) state_d = S_BODY;
                S_BODY: if ((flit_ty == TY_TAIL) || (flit_ty == TY_HT)) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Checker output: flag flits that are illegal in the current packet state.
    always_comb begin
        chk_err = 1'b0;
        if (in_valid) begin
            case (state_q)
                S_IDLE:  chk_err = (flit_ty == TY_BODY) || (flit_ty == TY_TAIL);
                S_BODY:  chk_err = (flit_ty == TY_HEAD) || (flit_ty == TY_HT);
                default: chk_err = 1'b0;
            endcase
        end
    end

    // Error pulse and saturating error counter next-state.
    always_comb begin
        pkt_err_d = chk_err;
        err_cnt_d = err_cnt_q;
        if (chk_err && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error reporting registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_err_q <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            pkt_err_q <= pkt_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign pkt_err = pkt_err_q;
    assign err_cnt = err_cnt_q;
`else
    assign pkt_err = 1'b0;
    assign err_cnt = 8'd0;
`endif

endmodule
